// File: rtl/hilo_muldiv_ctrl.sv
// Iterative signed multiply/divide sequencer owning the HI/LO registers.
// Optional HILO_DIV0_FLAG_EN: divide-by-zero leaves HI/LO untouched and pulses div_zero.
module hilo_muldiv_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             rd_hi,
  input  logic             rd_lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef HILO_DIV0_FLAG_EN
  ,
  output logic             div_zero
`endif
);

  localparam int unsigned AW = 2 * WIDTH + 1;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_FIX} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  // acc[AW-1:WIDTH]: partial product / remainder; acc[WIDTH-1:0]: multiplier / quotient
  logic [AW-1:0]   acc, acc_n;
  logic [WIDTH:0]  dvs, dvs_n;
  logic            sign_a, sign_a_n;
  logic            sign_q, sign_q_n;
  logic            is_mult, is_mult_n;
  logic            div0, div0_n;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic            busy_n, done_n;
`ifdef HILO_DIV0_FLAG_EN
  logic            div_zero_n;
`endif

  logic [WIDTH+1:0] mul_sum;
  logic [WIDTH:0]   div_rs;
  logic [WIDTH+1:0] div_diff;
  logic [PW-1:0]    prod_mag;
  logic [PW-1:0]    prod_s;
  logic [WIDTH-1:0] quo, rem;
  logic [WIDTH-1:0] quo_s, rem_s;

  // Unsigned magnitude is exact for the most-negative value in WIDTH bits.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? WIDTH'(-x) : x;
  endfunction

  assign stall = busy & (op_valid | rd_hi | rd_lo);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      dvs      <= '0;
      sign_a   <= 1'b0;
      sign_q   <= 1'b0;
      is_mult  <= 1'b0;
      div0     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef HILO_DIV0_FLAG_EN
      div_zero <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      acc      <= acc_n;
      dvs      <= dvs_n;
      sign_a   <= sign_a_n;
      sign_q   <= sign_q_n;
      is_mult  <= is_mult_n;
      div0     <= div0_n;
      hi       <= hi_n;
      lo       <= lo_n;
      busy     <= busy_n;
      done     <= done_n;
`ifdef HILO_DIV0_FLAG_EN
      div_zero <= div_zero_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    acc_n      = acc;
    dvs_n      = dvs;
    sign_a_n   = sign_a;
    sign_q_n   = sign_q;
    is_mult_n  = is_mult;
    div0_n     = div0;
    hi_n       = hi;
    lo_n       = lo;
    busy_n     = busy;
    done_n     = 1'b0;
`ifdef HILO_DIV0_FLAG_EN
    div_zero_n = 1'b0;
`endif

    mul_sum  = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, dvs} : '0);
    div_rs   = acc[AW-2:WIDTH-1];
    div_diff = {1'b0, div_rs} - {1'b0, dvs};
    prod_mag = acc[AW-2:0];
    prod_s   = sign_q ? PW'(-prod_mag) : prod_mag;
    quo      = acc[WIDTH-1:0];
    rem      = acc[AW-2:WIDTH];
    quo_s    = sign_q ? WIDTH'(-quo) : quo;
    rem_s    = sign_a ? WIDTH'(-rem) : rem;

    case (state)
      S_IDLE: begin
        if (op_valid) begin
          case (op_code)
            OP_MTHI: hi_n = src_a;
            OP_MTLO: lo_n = src_a;
            OP_MULT, OP_DIV: begin
              acc_n     = {(WIDTH + 1)'(0), mag(src_a)};
              dvs_n     = {1'b0, mag(src_b)};
              sign_a_n  = src_a[WIDTH-1];
              sign_q_n  = src_a[WIDTH-1] ^ src_b[WIDTH-1];
              is_mult_n = (op_code == OP_MULT);
              div0_n    = (op_code == OP_DIV) && (src_b == '0);
              cnt_n     = '0;
              busy_n    = 1'b1;
              state_n   = (op_code == OP_MULT) ? S_MULT : S_DIV;
            end
            default: ;
          endcase
        end
      end
      S_MULT: begin
        acc_n = {mul_sum, acc[WIDTH-1:1]};
        if (cnt == CW'(WIDTH - 1)) state_n = S_FIX;
        else                       cnt_n   = cnt + CW'(1);
      end
      S_DIV: begin
        // Restoring step: keep the subtraction only when it does not go negative.
        if (!div_diff[WIDTH+1]) acc_n = {div_diff[WIDTH:0], acc[WIDTH-2:0], 1'b1};
        else                    acc_n = {div_rs, acc[WIDTH-2:0], 1'b0};
        if (cnt == CW'(WIDTH - 1)) state_n = S_FIX;
        else                       cnt_n   = cnt + CW'(1);
      end
      S_FIX: begin
        if (is_mult) begin
          hi_n = prod_s[PW-1:WIDTH];
          lo_n = prod_s[WIDTH-1:0];
        end else if (div0) begin
`ifdef HILO_DIV0_FLAG_EN
          div_zero_n = 1'b1;
`else
          hi_n = rem_s;
          lo_n = '1;
`endif
        end else begin
          hi_n = rem_s;
          lo_n = quo_s;
        end
        busy_n  = 1'b0;
        done_n  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
